tag_lookup_ctrl: RTL

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/cache_pkg.sv | 32 +++
 rtl/tag_lookup_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared constants, entry layout and controller state encoding for the tag lookup path.
package cache_pkg;

    localparam int unsigned ADDR_W   = 36;
    localparam int unsigned INDEX_W  = 7;
    localparam int unsigned OFFS_W   = 6;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFS_W;
    localparam int unsigned ENTRY_W  = TAG_W + 1;
    localparam int unsigned NUM_SETS = 1 << INDEX_W;

    // Stored entry = {valid, tag}
    localparam int unsigned ENTRY_VALID_BIT = TAG_W;
    localparam int unsigned ENTRY_TAG_MSB   = TAG_W - 1;
    localparam int unsigned ENTRY_TAG_LSB   = 0;

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StFlush = 2'd2
    } state_e;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFS_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup controller: walks the tag RAM to invalidate it after reset/flush,
// installs fill tags and answers lookups with one cycle of latency.
module tag_lookup_ctrl
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [INDEX_W-1:0]  resp_index,
    output logic [TAG_W-1:0]    resp_tag,
    input  logic                fill_valid,
    output logic                fill_ready,
    input  logic [ADDR_W-1:0]   fill_addr,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done,
    output logic [INDEX_W-1:0]  ram_raddr,
    output logic                ram_re,
    output logic [INDEX_W-1:0]  ram_waddr,
    output logic [ENTRY_W-1:0]  ram_wr,
    output logic                ram_we,
    input  logic [ENTRY_W-1:0]  ram_rd
);

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   cnt_q, cnt_d;
    logic                 resp_valid_q;
    logic [INDEX_W-1:0]   index_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 flush_go;

    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   fill_index;
    logic [TAG_W-1:0]     fill_tag;
    logic                 unused_offs;

    assign req_index  = addr_index(req_addr);
    assign req_tag    = addr_tag(req_addr);
    assign fill_index = addr_index(fill_addr);
    assign fill_tag   = addr_tag(fill_addr);
    // Line offset bits play no part in tag lookup.
    assign unused_offs = ^{req_addr[OFFS_W-1:0], fill_addr[OFFS_W-1:0]};

    // State register and walk counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshakes and tag RAM port control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_go   = 1'b0;
        flush_done = 1'b0;
        busy       = 1'b0;
        fill_ready = 1'b0;
        req_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = cnt_q;
        ram_wr     = '0;
        ram_re     = 1'b0;
        ram_raddr  = req_index;

        unique case (state_q)
            StInit, StFlush: begin
                busy   = 1'b1;
                ram_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_INDEX) begin
                    flush_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            StIdle: begin
                // A flush waits for any presented response to drain first.
                flush_go   = flush_req && !resp_valid_q;
                fill_ready = !flush_go;
                req_ready  = fill_ready && !fill_valid && (!resp_valid_q || resp_ready);
                if (flush_go) begin
                    state_d = StFlush;
                end else if (fill_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = fill_index;
                    ram_wr    = {1'b1, fill_tag};
                end
                ram_re = req_valid && req_ready;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Response register; RAM read enable is held low during a stall so ram_rd stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            index_q      <= '0;
            tag_q        <= '0;
        end else if (ram_re) begin
            resp_valid_q <= 1'b1;
            index_q      <= req_index;
            tag_q        <= req_tag;
        end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_index = index_q;
    assign resp_tag   = tag_q;
    assign resp_hit   = resp_valid_q && ram_rd[ENTRY_VALID_BIT]
                        && (ram_rd[ENTRY_TAG_MSB:ENTRY_TAG_LSB] == tag_q);

endmodule
